// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             annul;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op_code, src_a, src_b, annul,
        input  op_ready, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, annul,
        output op_ready, busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; one shared radix-2 datapath.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for mult/multu.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    hilo_muldiv_unit_if.slave  bus
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               op_is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz_pend;
    logic               sign_wait;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               dz_q;

    // Operand conditioning for the capture edge.
    logic               accept;
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;

    assign accept    = bus.op_valid && (state == ST_IDLE) && !bus.annul;
    assign signed_op = !bus.op_code[0];
    assign a_neg     = signed_op && bus.src_a[WIDTH-1];
    assign b_neg     = signed_op && bus.src_b[WIDTH-1];
    assign a_mag_in  = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag_in  = b_neg ? -bus.src_b : bus.src_b;

    // One radix-2 step of either shift-add multiply or restoring divide.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_out;
    logic [WIDTH-1:0]   quot_out;
    logic [WIDTH-1:0]   rem_out;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        mul_sum   = '0;
        div_trial = '0;
        div_diff  = '0;
        step_acc  = acc;
        if (op_is_div) begin
            div_trial = acc[2*WIDTH-1:WIDTH-1];
            div_diff  = div_trial - {1'b0, b_mag};
            if (!div_diff[WIDTH])
                step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                step_acc = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign prod_out = neg_q ? -acc : acc;
    assign quot_out = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_out  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            op_is_div <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz_pend   <= 1'b0;
            sign_wait <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (bus.op_code)
                            OP_MTHI: begin
                                hi_q   <= bus.src_a;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= bus.src_a;
                                done_q <= 1'b1;
                            end
                            OP_MULT, OP_MULTU: begin
                                op_is_div <= 1'b0;
                                a_mag     <= a_mag_in;
                                b_mag     <= b_mag_in;
                                neg_q     <= a_neg ^ b_neg;
                                neg_r     <= a_neg;
                                dz_pend   <= 1'b0;
                                cnt       <= '0;
`ifdef MULDIV_FAST_MUL_EN
                                acc       <= {{WIDTH{1'b0}}, a_mag_in} * {{WIDTH{1'b0}}, b_mag_in};
                                state     <= ST_SIGN;
                                sign_wait <= 1'b1;
`else
                                acc       <= {{WIDTH{1'b0}}, b_mag_in};
                                state     <= ST_CALC;
                                sign_wait <= 1'b0;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                op_is_div <= 1'b1;
                                b_mag     <= b_mag_in;
                                neg_q     <= a_neg ^ b_neg;
                                neg_r     <= a_neg;
                                cnt       <= '0;
                                acc       <= {{WIDTH{1'b0}}, a_mag_in};
                                if (bus.src_b == '0) begin
                                    // Raw dividend is kept so HI reports it unchanged.
                                    a_mag     <= bus.src_a;
                                    dz_pend   <= 1'b1;
                                    state     <= ST_SIGN;
                                    sign_wait <= 1'b1;
                                end else begin
                                    a_mag     <= a_mag_in;
                                    dz_pend   <= 1'b0;
                                    state     <= ST_CALC;
                                    sign_wait <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    if (bus.annul) begin
                        state <= ST_IDLE;
                    end else begin
                        acc <= step_acc;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1))
                            state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    // Short paths (divide by zero, fast multiply) hold one cycle so they finish at T0+2.
                    if (bus.annul) begin
                        state <= ST_IDLE;
                    end else if (sign_wait) begin
                        sign_wait <= 1'b0;
                    end else begin
                        if (!op_is_div) begin
                            {hi_q, lo_q} <= prod_out;
                        end else if (dz_pend) begin
                            lo_q <= '1;
                            hi_q <= a_mag;
                        end else begin
                            lo_q <= quot_out;
                            hi_q <= rem_out;
                        end
                        done_q <= 1'b1;
                        dz_q   <= dz_pend;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.op_ready    = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit at WIDTH=32.
module tb_hilo_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk;
    logic resetn;
    int   tests_run;
    int   tests_failed;

    hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer an op before the next edge (T0), then count edges until done is seen.
    // lat is edges after T0 at which done is visible; 100 means it never came.
    task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cycles);
        bus.op_code  = code;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (lat < 100) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) break;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        resetn       = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'b000;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.annul    = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (bus.op_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_op_ready: got %b want 1", bus.op_ready); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests_run++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_done_dz: got %b%b want 00", bus.done, bus.div_by_zero); end
        tests_run++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin tests_failed++; $display("FAIL reset_hilo: got %h/%h want 0/0", bus.hi, bus.lo); end
    endtask

    task automatic test_divu();
        int lat, bc;
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bc);
        tests_run++; if (lat !== DIV_LAT) begin tests_failed++; $display("FAIL divu_latency: got %0d want %0d", lat, DIV_LAT); end
        tests_run++; if (bc !== 33) begin tests_failed++; $display("FAIL divu_busy_cycles: got %0d want 33", bc); end
        tests_run++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin tests_failed++; $display("FAIL divu_result: got hi=%h lo=%h want 2/e", bus.hi, bus.lo); end
        tests_run++; if (bus.div_by_zero !== 1'b0 || bus.op_ready !== 1'b1) begin tests_failed++; $display("FAIL divu_flags: got dz=%b rdy=%b want 0/1", bus.div_by_zero, bus.op_ready); end
        @(posedge clk); #1;
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL divu_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_div_signed();
        int lat, bc;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
        tests_run++; if (lat !== DIV_LAT) begin tests_failed++; $display("FAIL div_neg_latency: got %0d want %0d", lat, DIV_LAT); end
        tests_run++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL div_neg_result: got hi=%h lo=%h want ffffffff/fffffffd", bus.hi, bus.lo); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        tests_run++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin tests_failed++; $display("FAIL div_overflow: got hi=%h lo=%h want 0/80000000", bus.hi, bus.lo); end
        run_op(OP_DIV, 32'd45, 32'hFFFF_FFFA, lat, bc);
        tests_run++; if (bus.lo !== 32'hFFFF_FFF9 || bus.hi !== 32'd3) begin tests_failed++; $display("FAIL div_pos_neg: got hi=%h lo=%h want 3/fffffff9", bus.hi, bus.lo); end
    endtask

    task automatic test_mult();
        int lat, bc;
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, lat, bc);
        tests_run++; if (lat !== MUL_LAT) begin tests_failed++; $display("FAIL mult_latency: got %0d want %0d", lat, MUL_LAT); end
        tests_run++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL mult_result: got hi=%h lo=%h want ffffffff/fffffffe", bus.hi, bus.lo); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, lat, bc);
        tests_run++; if (lat !== MUL_LAT) begin tests_failed++; $display("FAIL multu_latency: got %0d want %0d", lat, MUL_LAT); end
        tests_run++; if (bus.hi !== 32'h1 || bus.lo !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL multu_result: got hi=%h lo=%h want 1/fffffffe", bus.hi, bus.lo); end
        run_op(OP_MULT, 32'h1234_5678, 32'hFFFF_FF00, lat, bc);
        tests_run++; if (bus.hi !== 32'hFFFF_FFED || bus.lo !== 32'hCBA9_8800) begin tests_failed++; $display("FAIL mult_mixed: got hi=%h lo=%h want ffffffed/cba98800", bus.hi, bus.lo); end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        run_op(OP_DIVU, 32'd5, 32'd0, lat, bc);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL dz_latency: got %0d want 2", lat); end
        tests_run++; if (bus.div_by_zero !== 1'b1) begin tests_failed++; $display("FAIL dz_flag: got %b want 1", bus.div_by_zero); end
        tests_run++; if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd5) begin tests_failed++; $display("FAIL dz_result: got hi=%h lo=%h want 5/ffffffff", bus.hi, bus.lo); end
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, lat, bc);
        tests_run++; if (bus.div_by_zero !== 1'b1 || bus.hi !== 32'hFFFF_FFFB || bus.lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL dz_signed: got dz=%b hi=%h lo=%h want 1/fffffffb/ffffffff", bus.div_by_zero, bus.hi, bus.lo); end
        run_op(OP_DIVU, 32'd9, 32'd3, lat, bc);
        tests_run++; if (bus.div_by_zero !== 1'b0 || bus.lo !== 32'd3 || bus.hi !== 32'd0) begin tests_failed++; $display("FAIL dz_cleared: got dz=%b hi=%h lo=%h want 0/0/3", bus.div_by_zero, bus.hi, bus.lo); end
    endtask

    task automatic test_moves_and_annul();
        int lat, bc;
        int seen_done;
        run_op(OP_MTHI, 32'h1234, 32'h0, lat, bc);
        tests_run++; if (lat !== 0 || bc !== 0 || bus.hi !== 32'h1234) begin tests_failed++; $display("FAIL mthi: got lat=%0d busy=%0d hi=%h want 0/0/1234", lat, bc, bus.hi); end
        run_op(OP_MTLO, 32'h5678, 32'h0, lat, bc);
        tests_run++; if (lat !== 0 || bus.lo !== 32'h5678 || bus.hi !== 32'h1234) begin tests_failed++; $display("FAIL mtlo: got lat=%0d hi=%h lo=%h want 0/1234/5678", lat, bus.hi, bus.lo); end
        // Start a divide, annul on edge T0+10.
        bus.op_code  = OP_DIV;
        bus.src_a    = 32'd1000;
        bus.src_b    = 32'd3;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.annul = 1'b1;
        @(posedge clk); #1;
        bus.annul = 1'b0;
        tests_run++; if (bus.op_ready !== 1'b1 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL annul_calc: got rdy=%b done=%b want 1/0", bus.op_ready, bus.done); end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen_done++;
        end
        tests_run++; if (seen_done !== 0) begin tests_failed++; $display("FAIL annul_no_done: got %0d done pulses want 0", seen_done); end
        tests_run++; if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin tests_failed++; $display("FAIL annul_hilo: got %h/%h want 1234/5678", bus.hi, bus.lo); end
        // op_valid with annul in IDLE must not be accepted.
        bus.op_code  = OP_MTHI;
        bus.src_a    = 32'hDEAD;
        bus.op_valid = 1'b1;
        bus.annul    = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.annul    = 1'b0;
        tests_run++; if (bus.done !== 1'b0 || bus.hi !== 32'h1234) begin tests_failed++; $display("FAIL annul_idle: got done=%b hi=%h want 0/1234", bus.done, bus.hi); end
        bus.op_code  = OP_DIVU;
        bus.src_a    = 32'd50;
        bus.src_b    = 32'd5;
        bus.op_valid = 1'b1;
        bus.annul    = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.annul    = 1'b0;
        tests_run++; if (bus.busy !== 1'b0 || bus.op_ready !== 1'b1) begin tests_failed++; $display("FAIL annul_idle_div: got busy=%b rdy=%b want 0/1", bus.busy, bus.op_ready); end
    endtask

    task automatic test_invalid_op();
        int seen_done;
        bus.op_code  = 3'b110;
        bus.src_a    = 32'hAAAA;
        bus.src_b    = 32'h5555;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.done || bus.busy) seen_done++;
            @(posedge clk); #1;
        end
        tests_run++; if (seen_done !== 0 || bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin tests_failed++; $display("FAIL invalid_op: got act=%0d hi=%h lo=%h want 0/1234/5678", seen_done, bus.hi, bus.lo); end
    endtask

    task automatic test_async_reset();
        bus.op_code  = OP_DIVU;
        bus.src_a    = 32'd777;
        bus.src_b    = 32'd7;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        tests_run++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin tests_failed++; $display("FAIL async_reset_hilo: got %h/%h want 0/0", bus.hi, bus.lo); end
        tests_run++; if (bus.busy !== 1'b0 || bus.op_ready !== 1'b1) begin tests_failed++; $display("FAIL async_reset_state: got busy=%b rdy=%b want 0/1", bus.busy, bus.op_ready); end
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL async_reset_discard: got done=%b busy=%b want 0/0", bus.done, bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(OP_MULT, 32'd3, 32'd4, lat, bc);
        tests_run++; if (lat !== MUL_LAT || bus.hi !== 32'h0 || bus.lo !== 32'd12) begin tests_failed++; $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h want %0d/0/c", lat, bus.hi, bus.lo, MUL_LAT); end
        tests_run++; if (bus.op_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_in_done: got %b want 1", bus.op_ready); end
        // Issued straight from the done cycle; acceptance shows as full latency.
        run_op(OP_MULTU, 32'd5, 32'd6, lat, bc);
        tests_run++; if (lat !== MUL_LAT || bus.lo !== 32'd30 || bus.hi !== 32'h0) begin tests_failed++; $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h want %0d/0/1e", lat, bus.hi, bus.lo, MUL_LAT); end
        run_op(OP_MTHI, 32'hCAFE, 32'h0, lat, bc);
        tests_run++; if (lat !== 0 || bus.hi !== 32'hCAFE || bus.lo !== 32'd30) begin tests_failed++; $display("FAIL b2b_move: got lat=%0d hi=%h lo=%h want 0/cafe/1e", lat, bus.hi, bus.lo); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_divu();
        test_div_signed();
        test_mult();
        test_div_by_zero();
        test_moves_and_annul();
        test_invalid_op();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
